// File: rtl/bpsk_tx_scheduler.sv
// bpsk_tx_scheduler: round-robin arbiter that frames one packet at a time
// (preamble, MSB-first payload, guard) onto the shared BPSK transmit chain.
module bpsk_tx_scheduler #(
  parameter int NUM_SOURCES   = 4,
  parameter int PACKET_SIZE   = 16,
  parameter int PREAMBLE_BITS = 8,
  parameter int GUARD_BITS    = 4,
  localparam int SRC_W        = $clog2(NUM_SOURCES)
) (
  input  logic                              i_clock,
  input  logic                              i_reset_n,
  input  logic                              i_bit_tick,
  input  logic [NUM_SOURCES-1:0]            i_req,
  input  logic [NUM_SOURCES*PACKET_SIZE-1:0] i_packet_in,
  output logic [NUM_SOURCES-1:0]            o_ack,
  output logic [NUM_SOURCES-1:0]            o_done,
  output logic [SRC_W-1:0]                  o_grant_id,
  output logic                              o_busy,
  output logic                              o_tx_enable,
  output logic                              o_current_bit
);
  localparam int MAX_A = PREAMBLE_BITS > PACKET_SIZE ? PREAMBLE_BITS : PACKET_SIZE;
  localparam int MAX_B = MAX_A > GUARD_BITS ? MAX_A : GUARD_BITS;
  localparam int CNT_W = $clog2(MAX_B > 2 ? MAX_B : 2);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PACKET_SIZE - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_BITS - 1);
  typedef enum logic [2:0] {IDLE, ARMED, PREAMBLE, PAYLOAD, GUARD} state_t;
  state_t                   r_state;
  logic [SRC_W-1:0]         r_rr_ptr;
  logic [SRC_W-1:0]         r_grant;
  logic [CNT_W-1:0]         r_cnt;
  logic [PACKET_SIZE-1:0]   r_shift;
  logic [NUM_SOURCES-1:0]   r_ack;
  logic [NUM_SOURCES-1:0]   r_done;
  logic                     r_tx;
  logic                     r_cur;
  logic [SRC_W-1:0]         w_winner;
  logic [SRC_W-1:0]         w_next_ptr;
  logic                     w_finish;
  int                       w_idx;
  // Scan offsets from highest to lowest so the nearest request to rr_ptr wins.
  always_comb begin
    w_winner = '0;
    w_idx    = 0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      w_idx = w_idx >= NUM_SOURCES ? w_idx - NUM_SOURCES : w_idx;
      if (i_req[w_idx]) w_winner = SRC_W'(w_idx);
    end
  end
  assign w_next_ptr = (r_grant == SRC_W'(NUM_SOURCES - 1)) ? '0 : r_grant + 1'b1;
  assign w_finish   = i_bit_tick &&
                      ((r_state == PAYLOAD && r_cnt == PKT_LAST && GUARD_BITS == 0) ||
                       (r_state == GUARD && r_cnt == GRD_LAST));
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_ack    <= '0;
      r_done   <= '0;
      r_tx     <= 1'b0;
      r_cur    <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      if (w_finish) begin
        r_state  <= IDLE;
        r_tx     <= 1'b0;
        r_cur    <= 1'b0;
        r_cnt    <= '0;
        r_done   <= NUM_SOURCES'(1) << r_grant;
        r_rr_ptr <= w_next_ptr;
      end else begin
        case (r_state)
          IDLE: if (|i_req) begin
            r_shift <= i_packet_in[w_winner*PACKET_SIZE +: PACKET_SIZE];
            r_grant <= w_winner;
            r_ack   <= NUM_SOURCES'(1) << w_winner;
            r_state <= ARMED;
          end
          ARMED: if (i_bit_tick) begin
            r_state <= PREAMBLE;
            r_tx    <= 1'b1;
            r_cur   <= 1'b1;
            r_cnt   <= '0;
          end
          PREAMBLE: if (i_bit_tick) begin
            if (r_cnt == PRE_LAST) begin
              r_state <= PAYLOAD;
              r_cur   <= r_shift[PACKET_SIZE-1];
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_cur <= ~r_cur;
            end
          end
          PAYLOAD: if (i_bit_tick) begin
            if (r_cnt == PKT_LAST) begin
              r_state <= GUARD;
              r_cur   <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_shift <= r_shift << 1;
              r_cur   <= r_shift[PACKET_SIZE-2];
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          GUARD: if (i_bit_tick) r_cnt <= r_cnt + 1'b1;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign o_ack         = r_ack;
  assign o_done        = r_done;
  assign o_grant_id    = r_grant;
  assign o_busy        = (r_state != IDLE);
  assign o_tx_enable   = r_tx;
  assign o_current_bit = r_cur;
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// tb_bpsk_tx_scheduler: directed checks of arbitration, framing and reset behaviour.
module tb_bpsk_tx_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [3:0]  req = '0, req0 = '0;
  logic [63:0] pkt = '0;
  logic [3:0]  ack, done, ack0, done0;
  logic [1:0]  gid, gid0;
  logic        busy, tx, cur, busy0, tx0, cur0;
  int          total = 0, bad = 0;

  bpsk_tx_scheduler u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_bit_tick(tick), .i_req(req), .i_packet_in(pkt),
    .o_ack(ack), .o_done(done), .o_grant_id(gid), .o_busy(busy),
    .o_tx_enable(tx), .o_current_bit(cur));

  bpsk_tx_scheduler #(.GUARD_BITS(0)) u_dut_g0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_bit_tick(tick), .i_req(req0), .i_packet_in(pkt),
    .o_ack(ack0), .o_done(done0), .o_grant_id(gid0), .o_busy(busy0),
    .o_tx_enable(tx0), .o_current_bit(cur0));

  always #5 clk = ~clk;

  function automatic logic ebit(logic [15:0] p, int i);
    if (i < 8) return ~i[0];
    else if (i < 24) return p[23-i];
    else return 1'b0;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse();
    tick = 1'b1; cyc(1); tick = 1'b0;
  endtask

  task automatic grant(int s);
    cyc(1);
    chk("ack", ack, 32'(1 << s));
    chk("grant_id", gid, s);
    chk("busy", busy, 1);
    chk("done_low", done, 0);
  endtask

  task automatic bits(logic [15:0] p, int from, int n, int per);
    for (int i = from; i < from + n; i++) begin
      pulse();
      chk($sformatf("bit%0d", i), cur, ebit(p, i));
      chk("tx_on", tx, 1);
      chk("no_ack", ack, 0);
      cyc(per - 1);
      chk($sformatf("hold%0d", i), cur, ebit(p, i));
    end
  endtask

  task automatic finish(int s);
    pulse();
    chk("done", done, 32'(1 << s));
    chk("tx_off", tx, 0);
    chk("cur_off", cur, 0);
    chk("idle", busy, 0);
  endtask

  initial begin
    cyc(3);
    chk("reset_outs", {ack, done, gid, busy, tx, cur}, 0);
    rst_n = 1'b1;
    // single frame, 64-clock bit period
    pkt[15:0] = 16'hCAFE;
    req = 4'b0001;
    grant(0);
    req = '0;
    bits(16'hCAFE, 0, 28, 64);
    finish(0);
    cyc(1);
    chk("done_one_cycle", done, 0);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    // round robin with all requests held
    pkt = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      grant(k % 4);
      bits(16'(16'h1111 * (k % 4 + 1)), 0, 28, 8);
      finish(k % 4);
    end
    req = '0;
    // tick coincident with grant edge must be ignored
    req = 4'b0100; tick = 1'b1;
    grant(2);
    tick = 1'b0; req = '0;
    chk("armed_tx", tx, 0);
    chk("armed_cur", cur, 0);
    cyc(5);
    chk("armed_wait_tx", tx, 0);
    bits(16'h3333, 0, 28, 8);
    finish(2);
    // lone repeating requester
    req = 4'b1000;
    grant(3);
    bits(16'h4444, 0, 28, 8);
    finish(3);
    grant(3);
    req = '0;
    bits(16'h4444, 0, 28, 8);
    finish(3);
    // reset during payload bit 5
    req = 4'b0010;
    grant(1);
    req = '0;
    bits(16'h2222, 0, 13, 8);
    pulse();
    chk("pay5", cur, ebit(16'h2222, 13));
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {ack, done, gid, busy, tx, cur}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("no_done_after_abort", done, 0);
    chk("idle_after_abort", busy, 0);
    req = 4'b0100;
    grant(2);
    req = '0;
    bits(16'h3333, 0, 28, 8);
    finish(2);
    // zero-guard build ends on the payload LSB tick
    req0 = 4'b0001;
    cyc(1);
    chk("g0_ack", ack0, 1);
    req0 = '0;
    for (int i = 0; i < 24; i++) begin
      pulse();
      chk($sformatf("g0_bit%0d", i), cur0, ebit(16'h1111, i));
      chk("g0_tx", tx0, 1);
      cyc(7);
    end
    pulse();
    chk("g0_done", done0, 1);
    chk("g0_tx_off", tx0, 0);
    chk("g0_idle", busy0, 0);
    chk("main_idle", busy, 0);
    cyc(1);
    chk("g0_done_low", done0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bpsk_tx_scheduler.md
Name: bpsk_tx_scheduler

Overview:
- Shares the single BPSK transmit chain between NUM_SOURCES packet requesters using round-robin arbitration.
- Frames each granted packet as preamble, then payload (MSB first), then guard bits.
- Drives current_bit into the phase-flip counter, stepping only on the per-bit boundary pulse from that counter.
- Replaces the fixed-packet data_send path in Main.

Parameters:
NUM_SOURCES, 4, number of requesters (>=2)
PACKET_SIZE, 16, payload bits per packet
PREAMBLE_BITS, 8, alternating 1,0,... bits sent before payload (>=1)
GUARD_BITS, 4, zero bits sent after payload with carrier still enabled (0 allowed)
SRC_W, $clog2(NUM_SOURCES), local, width of grant_id

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
bit_tick  in  1  one-cycle pulse at each bit boundary (next_bit_signal from phase_clock)
req  in  NUM_SOURCES  per-source request; held high with packet stable until ack
packet_in  in  NUM_SOURCES*PACKET_SIZE  source k packet at bits [k*PACKET_SIZE +: PACKET_SIZE]
ack  out  NUM_SOURCES  one-hot, one-cycle pulse: packet latched
done  out  NUM_SOURCES  one-hot, one-cycle pulse: last framed bit finished
grant_id  out  SRC_W  index of the source being served; valid while busy
busy  out  1  high in any state other than IDLE
tx_enable  out  1  high while PREAMBLE/PAYLOAD/GUARD bits are on air
current_bit  out  1  bit to modulate

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, bit counter=0, shift register=0. All outputs 0.
- Reset mid-packet: frame aborted, no done issued, latched packet discarded.
- IDLE, at a clock edge with req!=0:
  - Winner = first set req bit searching rr_ptr, rr_ptr+1, ... modulo NUM_SOURCES.
  - Latch winner's packet slice into shift register; grant_id=winner.
  - ack[winner]=1 for exactly the next cycle; go to ARMED.
  - bit_tick is ignored in IDLE, including a tick on the grant edge.
- ARMED: wait for bit_tick.
  - On tick: go to PREAMBLE, current_bit=1, tx_enable=1, count=0.
  - This aligns the first bit to a full bit period.
- PREAMBLE, on each tick:
  - If count==PREAMBLE_BITS-1: go to PAYLOAD, current_bit=shift MSB, count=0.
  - Otherwise: count++, current_bit toggles.
- PAYLOAD, on each tick:
  - If count==PACKET_SIZE-1 and GUARD_BITS>0: go to GUARD, current_bit=0, count=0.
  - If count==PACKET_SIZE-1 and GUARD_BITS==0: finish (see below).
  - Otherwise: shift left, current_bit=new MSB, count++.
- GUARD, on each tick: if count==GUARD_BITS-1, finish; otherwise count++. current_bit stays 0.
- Finish (same edge):
  - state=IDLE, tx_enable=0, current_bit=0.
  - done[grant_id]=1 for one cycle.
  - rr_ptr=(grant_id+1) mod NUM_SOURCES.
  - A pending req may be granted on the following edge, not the finish edge.
- Between ticks all outputs hold their values.
- Each on-air bit lasts exactly one tick-to-tick interval.
- req changes outside IDLE are ignored.
- A req dropped before grant is simply not served.
- A requester that keeps req high after ack is re-arbitrated as a new packet once the scheduler returns to IDLE.
- Counter width: $clog2(max(PREAMBLE_BITS, PACKET_SIZE, GUARD_BITS, 2)).
- No arithmetic overflow is possible. rr_ptr wraps from NUM_SOURCES-1 to 0.

Test Plan:
- Single frame: ticks every 64 clocks; req=4'b0001, source 0 packet=16'hCAFE -> ack[0] one cycle after req; after the next tick current_bit=1,0,1,0,1,0,1,0, then 1100101011111110, then 0000; tx_enable high 28 bit periods; done[0] one cycle at end.
- Round-robin: req=4'b1111 held, packets 16'h1111/2222/3333/4444 -> grant order 0,1,2,3,0; each payload matches its source; no ack while busy.
- Tick on grant edge: req rises so that the grant edge coincides with bit_tick -> that tick is not counted; first preamble bit appears on the following tick with a full period.
- Lone repeat requester: only source 3 requests twice in sequence -> granted both times (rr_ptr=0 after the first); done[3] pulses twice.
- Reset mid-payload: assert reset_n=0 during payload bit 5 -> all outputs 0 immediately, no done; after release, req=4'b0100 -> source 2 granted (rr_ptr=0 search).
- GUARD_BITS=0 build: frame ends right after payload LSB; done pulses on that tick edge.
